data_memory_banked: RTL and testbench

- Parametrised successor to the single-port 24-bit data memory in the MIPS datapath.
- Word-addressed RAM with configurable width and depth, byte-lane write enables and a registered one-cycle read with valid strobe.
- Write-first read-during-write bypass, out-of-range address detection, and a post-reset clear engine that zeroes every word before accepting requests.
- Sits between the EX/MEM pipeline register and MEM/WB; the pipeline stalls on ready=0.

---
 rtl/data_mem_pkg.sv | 34 +++
 rtl/data_mem_clear_fsm.sv | 57 +++++
 rtl/data_memory_banked.sv | 114 +++++++++++
 tb/tb_data_memory_banked.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the banked data memory: FSM states,
// derived widths and the byte-lane merge used by the write-first bypass.
package data_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  // Widest word the merge helper handles; callers zero-extend into this.
  localparam int MERGE_MAX_W = 64;

  function automatic int lanes_f(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction

  function automatic int idx_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic logic [MERGE_MAX_W-1:0] merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_W-1:0] byte_en,
    input int                     byte_w
  );
    logic [MERGE_MAX_W-1:0] res;
    for (int i = 0; i < MERGE_MAX_W; i++) begin
      res[i] = byte_en[i / byte_w] ? new_w[i] : old_w[i];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_mem_clear_fsm.sv
// Post-reset clear sequencer: walks every word index once, then holds
// ready high until the next reset.
module data_mem_clear_fsm
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int IDX_W = 11
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             ready,
  output logic             clear_we,
  output logic [IDX_W-1:0] clear_idx
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clear_idx_q, clear_idx_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    clear_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clear_we = 1'b1;
        // The last word is written on the same edge that raises ready.
        if (clear_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d     = ST_IDLE;
          clear_idx_d = '0;
        end else begin
          clear_idx_d = clear_idx_q + IDX_W'(1);
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  assign ready     = (state_q == ST_IDLE);
  assign clear_idx = clear_idx_q;

endmodule

// File: rtl/data_memory_banked.sv
// Word-addressed data memory with byte-lane writes, registered read with
// valid strobe, write-first bypass, range checking and post-reset clear.
module data_memory_banked
  import data_mem_pkg::*;
#(
  parameter  int DATA_W = 24,
  parameter  int BYTE_W = 8,
  parameter  int DEPTH  = 2048,
  parameter  int ADDR_W = 24,
  localparam int LANES  = lanes_f(DATA_W, BYTE_W)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [LANES-1:0]  byte_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = idx_w_f(DEPTH);

  logic [DATA_W-1:0] ram [DEPTH];

  logic                   clear_we;
  logic [IDX_W-1:0]       clear_idx;
  logic                   in_range, wr_ok, rd_ok;
  logic [IDX_W-1:0]       req_idx, wr_idx;
  logic [LANES-1:0]       lane_we;
  logic [DATA_W-1:0]      wr_word, old_word;
  logic [MERGE_MAX_W-1:0] old_ext, new_ext, be_ext, merged_ext;
  logic [DATA_W-1:0]      read_data_q, read_data_d;
  logic                   read_valid_q, read_valid_d;
  logic                   addr_err_q, addr_err_d;

  data_mem_clear_fsm #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_fsm (
    .clock     (clock),
    .reset_n   (reset_n),
    .ready     (ready),
    .clear_we  (clear_we),
    .clear_idx (clear_idx)
  );

  always_comb begin
    // Range check on the full address so high bits never alias low words.
    in_range = (address < ADDR_W'(DEPTH));
    req_idx  = address[IDX_W-1:0];
    wr_ok    = ready & mem_write & in_range;
    rd_ok    = ready & mem_read & in_range;
    old_word = ram[req_idx];

    old_ext = '0;
    new_ext = '0;
    be_ext  = '0;
    old_ext[DATA_W-1:0] = old_word;
    new_ext[DATA_W-1:0] = write_data;
    be_ext[LANES-1:0]   = byte_en;
    merged_ext = merge(old_ext, new_ext, be_ext, BYTE_W);

    if (clear_we) begin
      wr_idx  = clear_idx;
      lane_we = '1;
      wr_word = '0;
    end else begin
      wr_idx  = req_idx;
      lane_we = wr_ok ? byte_en : '0;
      wr_word = write_data;
    end

    // A read to the word being written returns the post-write contents.
    read_data_d = read_data_q;
    if (ready && mem_read) begin
      if (rd_ok) begin
        read_data_d = wr_ok ? merged_ext[DATA_W-1:0] : old_word;
      end else begin
        read_data_d = '0;
      end
    end
    read_valid_d = ready & mem_read;
    addr_err_d   = ready & (mem_read | mem_write) & ~in_range;
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < LANES; k++) begin
      if (lane_we[k]) begin
        ram[wr_idx][k*BYTE_W +: BYTE_W] <= wr_word[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_data_memory_banked.sv
// Randomized bench for data_memory_banked against an array-based reference
// model of the memory contents, plus directed boundary and reset cases.
module tb_data_memory_banked;

  localparam int DEPTH = 2048;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        mem_write, mem_read;
  logic [2:0]  byte_en;
  logic [23:0] address, write_data;
  logic [23:0] read_data;
  logic        read_valid, ready, addr_err;

  int checks = 0;
  int errors = 0;

  logic [23:0] mem [DEPTH];
  logic [23:0] exp_data;

  always #5 clock = ~clock;

  data_memory_banked dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .byte_en    (byte_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .ready      (ready),
    .addr_err   (addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] lane_merge(input logic [23:0] old_w, input logic [23:0] nw,
                                             input logic [2:0] be);
    logic [23:0] r;
    r = old_w;
    for (int k = 0; k < 3; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    byte_en    = 3'b000;
    address    = 24'd0;
    write_data = 24'd0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem[i] = 24'd0;
  endtask

  // One request cycle while the memory is ready; compares all outputs.
  task automatic do_cycle(input logic wr, input logic rd, input logic [2:0] be,
                          input logic [23:0] addr, input logic [23:0] wd);
    logic        inr;
    logic        exp_err;
    logic [23:0] cur;
    mem_write  = wr;
    mem_read   = rd;
    byte_en    = be;
    address    = addr;
    write_data = wd;
    inr     = (addr < 24'(DEPTH));
    exp_err = (rd | wr) & ~inr;
    if (rd) begin
      cur = inr ? mem[addr[10:0]] : 24'd0;
      if (inr && wr) cur = lane_merge(cur, wd, be);
      exp_data = cur;
    end
    if (wr && inr) mem[addr[10:0]] = lane_merge(mem[addr[10:0]], wd, be);
    @(posedge clock);
    #1;
    chk("read_valid", 32'(read_valid), 32'(rd));
    chk("addr_err", 32'(addr_err), 32'(exp_err));
    chk("read_data", 32'(read_data), 32'(exp_data));
    chk("ready", 32'(ready), 32'd1);
    idle_inputs();
  endtask

  // Counts edges until ready while hammering requests that must be ignored.
  task automatic run_clear(input int stop_at, output int n, output int bad);
    n   = 0;
    bad = 0;
    while (ready !== 1'b1 && n < 3000 && (stop_at == 0 || n < stop_at)) begin
      mem_read   = 1'($urandom_range(0, 1));
      mem_write  = 1'($urandom_range(0, 1));
      byte_en    = 3'($urandom);
      address    = 24'($urandom_range(0, 2100));
      write_data = 24'($urandom);
      @(posedge clock);
      #1;
      n++;
      if (read_valid !== 1'b0 || addr_err !== 1'b0) bad++;
    end
    idle_inputs();
  endtask

  task automatic rand_cycles(input int count);
    int          r;
    logic [23:0] a;
    for (int i = 0; i < count; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = 24'(DEPTH + int'($urandom_range(0, 20)));
      else if (r == 1) a = 24'($urandom_range(2030, 2047));
      else if (r == 2) a = 24'($urandom);
      else             a = 24'($urandom_range(0, 15));
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom), a,
               24'($urandom));
    end
  endtask

  initial begin
    int n, bad;
    reset_n = 1'b0;
    idle_inputs();
    exp_data = 24'd0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_valid", 32'(read_valid), 32'd0);
    chk("rst_data", 32'(read_data), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);

    reset_n = 1'b1;
    run_clear(0, n, bad);
    chk("clear_len", 32'(n), 32'(DEPTH));
    chk("clear_quiet", 32'(bad), 32'd0);
    model_clear();

    do_cycle(1'b0, 1'b1, 3'b000, 24'd0, 24'd0);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd1000, 24'd0);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd2047, 24'd0);
    chk("zero_2047", 32'(read_data), 32'h0);
    do_cycle(1'b1, 1'b0, 3'b111, 24'd5, 24'hABCDEF);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd5, 24'd0);
    chk("full_write", 32'(read_data), 32'hABCDEF);
    do_cycle(1'b1, 1'b0, 3'b010, 24'd5, 24'h112233);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd5, 24'd0);
    chk("lane_write", 32'(read_data), 32'hAB22EF);
    do_cycle(1'b1, 1'b1, 3'b101, 24'd7, 24'h445566);
    chk("wr_first", 32'(read_data), 32'h440066);
    do_cycle(1'b1, 1'b0, 3'b111, 24'd2048, 24'h123456);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd2048, 24'd0);
    chk("oor_read", 32'(read_data), 32'h0);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd0, 24'd0);
    do_cycle(1'b1, 1'b0, 3'b111, 24'd2053, 24'h777777);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd5, 24'd0);
    chk("no_alias", 32'(read_data), 32'hAB22EF);
    do_cycle(1'b1, 1'b0, 3'b000, 24'd5, 24'hFFFFFF);
    do_cycle(1'b0, 1'b0, 3'b000, 24'd0, 24'd0);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd5, 24'd0);

    rand_cycles(500);

    // Asynchronous reset while a read result is being presented.
    do_cycle(1'b0, 1'b1, 3'b000, 24'd5, 24'd0);
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(read_valid), 32'd0);
    chk("arst_data", 32'(read_data), 32'd0);
    chk("arst_ready", 32'(ready), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_clear(1000, n, bad);
    chk("partial_len", 32'(n), 32'd1000);
    chk("partial_quiet", 32'(bad), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_clear(0, n, bad);
    chk("reclear_len", 32'(n), 32'(DEPTH));
    chk("reclear_quiet", 32'(bad), 32'd0);
    model_clear();
    exp_data = 24'd0;

    do_cycle(1'b0, 1'b1, 3'b000, 24'd5, 24'd0);
    chk("reclear_5", 32'(read_data), 32'h0);
    do_cycle(1'b0, 1'b1, 3'b000, 24'd7, 24'd0);
    rand_cycles(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
